// File: rtl/axi4_arb_pkg.sv
// Shared types and sizing helpers for the AXI4 read arbiter.
// Burst/response encodings, clog2, and slave-side ID width rules.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int midx_w(input int nm);
    return (nm < 2) ? 1 : clog2(nm);
  endfunction

  function automatic int sid_w(input int idw, input int nm);
    return idw + midx_w(nm);
  endfunction

endpackage

// File: rtl/axi4_read_arbiter_rr.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), gnt_idx, any_gnt out.
module axi4_rr_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  localparam int MIDX_W = midx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MIDX_W-1:0]      ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [MIDX_W-1:0]      gnt_idx,
  output logic                   any_gnt
);

  logic [MIDX_W-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = MIDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!any_gnt && req[j]) begin
        any_gnt = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// N-to-1 AXI4 read arbiter: round-robin AR slot, per-master outstanding
// limit, {master,id} ID prefixing, R routed back by the ID prefix.
// Ports: ACLK/ARESET; m_ar*/m_r* per master (flattened); s_ar*/s_r* slave;
// route_err sticky flag for R beats to unknown/idle masters.
module axi4_read_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int MIDX_W    = midx_w(NUM_MASTERS),
  localparam int SID_WIDTH = ID_WIDTH + MIDX_W
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_MASTERS-1:0]          m_arvalid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]        m_arlen,
  input  logic [NUM_MASTERS*3-1:0]        m_arsize,
  input  logic [NUM_MASTERS*2-1:0]        m_arburst,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0] m_arid,
  output logic [NUM_MASTERS-1:0]          m_arready,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [DATA_WIDTH-1:0]           m_rdata,
  output logic [1:0]                      m_rresp,
  output logic                            m_rlast,
  output logic [ID_WIDTH-1:0]             m_rid,
  input  logic [NUM_MASTERS-1:0]          m_rready,
  output logic                            s_arvalid,
  output logic [ADDR_WIDTH-1:0]           s_araddr,
  output logic [7:0]                      s_arlen,
  output logic [2:0]                      s_arsize,
  output logic [1:0]                      s_arburst,
  output logic [SID_WIDTH-1:0]            s_arid,
  input  logic                            s_arready,
  input  logic                            s_rvalid,
  input  logic [DATA_WIDTH-1:0]           s_rdata,
  input  logic [1:0]                      s_rresp,
  input  logic                            s_rlast,
  input  logic [SID_WIDTH-1:0]            s_rid,
  output logic                            s_rready,
  output logic                            route_err
);

  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);

  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [2:0]              arsize_q, arsize_d;
  logic [1:0]              arburst_q, arburst_d;
  logic [SID_WIDTH-1:0]    arid_q, arid_d;
  logic [MIDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                    route_err_q, route_err_d;

  logic                    load_en;
  logic [NUM_MASTERS-1:0]  req;
  logic [NUM_MASTERS-1:0]  gnt;
  logic [MIDX_W-1:0]       gnt_idx;
  logic                    any_gnt;
  logic [MIDX_W-1:0]       r_idx;
  logic                    r_hit;
  logic                    r_hs;
  logic                    inc, dec;

  assign load_en = !arvalid_q || s_arready;

  // Reset is folded in so no master sees a grant while held in reset.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      req[i] = m_arvalid[i] && load_en && !ARESET
               && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
  end

  axi4_rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr (
    .req    (req),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any_gnt(any_gnt)
  );

  assign m_arready = gnt;

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arid_d    = arid_q;
    rr_ptr_d  = rr_ptr_q;
    if (load_en) begin
      arvalid_d = any_gnt;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (gnt[i]) begin
          araddr_d  = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          arlen_d   = m_arlen[i*8 +: 8];
          arsize_d  = m_arsize[i*3 +: 3];
          arburst_d = m_arburst[i*2 +: 2];
          arid_d    = {gnt_idx, m_arid[i*ID_WIDTH +: ID_WIDTH]};
          rr_ptr_d  = MIDX_W'((i + 1) % NUM_MASTERS);
        end
      end
    end
  end

  assign r_idx = s_rid[SID_WIDTH-1:ID_WIDTH];
  assign r_hit = int'(r_idx) < NUM_MASTERS;

  // Beats with an out-of-range prefix are sunk so the slave never stalls.
  always_comb begin
    m_rvalid = '0;
    s_rready = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_idx == MIDX_W'(i)) begin
        m_rvalid[i] = s_rvalid;
        s_rready    = m_rready[i];
      end
    end
  end

  assign r_hs    = s_rvalid && s_rready;
  assign m_rid   = s_rid[ID_WIDTH-1:0];
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  always_comb begin
    cnt_d       = cnt_q;
    route_err_d = route_err_q || (r_hs && !r_hit);
    inc         = 1'b0;
    dec         = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      inc = gnt[i];
      dec = r_hs && s_rlast && r_hit && (r_idx == MIDX_W'(i));
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) route_err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      arid_q      <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      route_err_q <= 1'b0;
    end else begin
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      arid_q      <= arid_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      route_err_q <= route_err_d;
    end
  end

  assign s_arvalid = arvalid_q;
  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arsize  = arsize_q;
  assign s_arburst = arburst_q;
  assign s_arid    = arid_q;
  assign route_err = route_err_q;

endmodule

// File: doc/axi4_read_arbiter.md
Name: axi4_read_arbiter

Overview:
- N-to-1 AXI4 read-channel arbiter that shares one AXI4 slave read port (AR + R) between NUM_MASTERS requesters.
- Sits between multiple read masters and a single AXI4 slave, in front of the same signal interface the AXI4 monitor observes.
- Round-robin AR scheduling, per-master outstanding-transaction limiting, master-index ID prefixing, and R-channel routing back to the owning master by ID.

Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..8.
- ADDR_WIDTH, 32: AR address width.
- DATA_WIDTH, 32: R data width.
- ID_WIDTH, 4: master-side ID width. Slave-side ID width is SID_WIDTH = ID_WIDTH + MIDX_W, where MIDX_W = clog2(NUM_MASTERS).
- MAX_OUTSTANDING, 8: maximum open read bursts per master, 1..15.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  asynchronous reset, active-high.
- m_arvalid  in  NUM_MASTERS  per-master AR valid.
- m_araddr  in  NUM_MASTERS*ADDR_WIDTH  flattened AR address, master i at slice i.
- m_arlen  in  NUM_MASTERS*8  flattened burst length.
- m_arsize  in  NUM_MASTERS*3  flattened burst size.
- m_arburst  in  NUM_MASTERS*2  flattened burst type.
- m_arid  in  NUM_MASTERS*ID_WIDTH  flattened AR ID.
- m_arready  out  NUM_MASTERS  per-master AR ready.
- m_rvalid  out  NUM_MASTERS  per-master R valid.
- m_rdata  out  DATA_WIDTH  R data, broadcast to all masters.
- m_rresp  out  2  R response, broadcast.
- m_rlast  out  1  R last, broadcast.
- m_rid  out  ID_WIDTH  R ID with the master-index prefix stripped, broadcast.
- m_rready  in  NUM_MASTERS  per-master R ready.
- s_arvalid  out  1  slave AR valid.
- s_araddr  out  ADDR_WIDTH  slave AR address.
- s_arlen  out  8  slave burst length.
- s_arsize  out  3  slave burst size.
- s_arburst  out  2  slave burst type.
- s_arid  out  SID_WIDTH  slave AR ID, formed as {master index, m_arid}.
- s_arready  in  1  slave AR ready.
- s_rvalid  in  1  slave R valid.
- s_rdata  in  DATA_WIDTH  slave R data.
- s_rresp  in  2  slave R response.
- s_rlast  in  1  slave R last.
- s_rid  in  SID_WIDTH  slave R ID.
- s_rready  out  1  slave R ready.
- route_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): s_arvalid=0, all s_ar* payload=0, m_arready=0, every outstanding counter=0, rr_ptr=0, route_err=0. Reset mid-burst discards all in-flight state; no recovery of open bursts.
- AR output register (one slot):
  - load_en = !s_arvalid || s_arready.
  - Master i is eligible when m_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
  - When load_en=1 and at least one master is eligible, the round-robin picker selects the first eligible index starting from rr_ptr and wrapping modulo NUM_MASTERS.
  - m_arready[g] is asserted combinationally in that cycle; all other m_arready bits are 0.
  - On the next edge: payload and s_arid={g, m_arid[g]} are captured, s_arvalid=1, rr_ptr=(g+1) mod NUM_MASTERS.
  - When load_en=1 and no master is eligible: s_arvalid clears on the edge if s_arready was 1; rr_ptr is unchanged.
  - Latency is 1 cycle from m handshake to s_arvalid. Back-to-back throughput is 1 AR per cycle while s_arready=1.
  - s_arvalid and payload stay stable while s_arready=0 (AXI4 rule). m_arready is 0 for all masters while the slot is full and stalled.
- Outstanding counters, one per master, width clog2(MAX_OUTSTANDING+1):
  - +1 on m AR handshake for that master.
  - -1 on an R handshake with s_rlast=1 routed to that master.
  - Both in the same cycle: counter unchanged.
  - Decrement at 0: counter stays 0 and route_err is set.
  - Increment at MAX cannot occur (master is ineligible at MAX).
- R routing (combinational, no added latency):
  - idx = s_rid[SID_WIDTH-1:ID_WIDTH].
  - If idx < NUM_MASTERS: m_rvalid[idx]=s_rvalid, other m_rvalid bits=0, s_rready=m_rready[idx].
  - m_rid = s_rid[ID_WIDTH-1:0]; m_rdata, m_rresp and m_rlast pass through s_r* unchanged.
  - If idx >= NUM_MASTERS (non-power-of-two NUM_MASTERS): s_rready=1 (beat sunk), all m_rvalid=0, route_err set on the handshake.
- AR and R paths are independent. An AR grant and an R-last for the same master in the same cycle are both honoured.

Decomposition:
- Package axi4_arb_pkg:
  - burst-type enum (FIXED/INCR/WRAP);
  - RRESP constants (OKAY/EXOKAY/SLVERR/DECERR);
  - a clog2 helper function;
  - localparam rules for MIDX_W and SID_WIDTH.
- Sub-module axi4_rr_arbiter: combinational round-robin picker.
  - Inputs: req[NUM_MASTERS], ptr.
  - Outputs: gnt one-hot, gnt_idx, any_gnt.
  - Instantiated once for the AR channel.

Test Plan:
- Reset checks: assert ARESET mid-stream with s_arvalid=1 and cnt[1]=3 → s_arvalid=0, all m_arready=0, cnt=0, route_err=0 immediately, without waiting for a clock edge.
- Fairness: all 4 masters hold m_arvalid=1, s_arready=1 constantly → grants occur in order 0,1,2,3,0,..., s_arid upper bits match, 1 AR per cycle.
- Stall: s_arready=0 for 5 cycles after a grant to master 2 with araddr=0x1000 → s_arvalid and payload stable, m_arready all 0; single transfer on release.
- Limit: MAX_OUTSTANDING=2; master 0 issues 2 ARs with no R → third request blocked while master 1 is still granted; after an R beat with s_rlast=1 and s_rid={0,4'h5}, master 0 is granted again.
- Routing: s_rid={2'd3,4'hA}, s_rvalid=1, m_rready[3]=0 for 2 cycles → m_rvalid=4'b1000, m_rid=4'hA, s_rready=0; beat completes when m_rready[3]=1.
- Errors: NUM_MASTERS=3 with s_rid upper bits=2'd3 → s_rready=1, no m_rvalid, route_err=1 sticky. Separately, an R-last to a master with cnt=0 → route_err=1 and the counter stays 0.
